verif_trama: RTL

Frame checker and receive buffer placed directly downstream of the UART bit-capture stage. It detects completion of each 10-bit frame, checks the start and stop bits, and extracts the data byte. Valid bytes go into a small show-ahead FIFO with a valid/ready handshake toward the consumer. Framing errors and overruns are flagged as single-cycle pulses.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/verif_trama_fifo_rx.sv | 53 +++++
 rtl/verif_trama.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-side definitions: frame bit positions, checker FSM
// encoding and counter limit.
package uart_pkg;

    localparam int BIT_INICIO  = 0;
    localparam int LSB_DATO    = 1;
    localparam int MSB_DATO    = 8;
    localparam int BIT_PARADA  = 9;
    localparam int ANCHO_TRAMA = 10;

    localparam logic [7:0] CONT_MAX = 8'd255;

    typedef enum logic {
        ESPERA   = 1'b0,
        VERIFICA = 1'b1
    } estado_t;

    // A frame is well formed when the start bit is low and the stop bit is high.
    function automatic logic trama_ok(input logic [ANCHO_TRAMA-1:0] t);
        return (t[BIT_INICIO] == 1'b0) && (t[BIT_PARADA] == 1'b1);
    endfunction

endpackage

// File: rtl/verif_trama_fifo_rx.sv
// fifo_rx: show-ahead byte FIFO, PROF entries, pointers one bit wider than the
// address so full and empty are told apart by the MSB.
module fifo_rx
    import uart_pkg::*;
#(
    parameter  int PROF = 4,
    localparam int AP   = $clog2(PROF)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en,
    input  logic [7:0]    wr_dato,
    input  logic          rd_en,
    output logic [7:0]    rd_dato,
    output logic          full,
    output logic          empty,
    output logic [AP:0]   nivel
);

    logic [7:0]  mem [PROF];
    logic [AP:0] wr_ptr;
    logic [AP:0] rd_ptr;
    logic        rd_do;
    logic        wr_do;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AP] != rd_ptr[AP]) &&
                   (wr_ptr[AP-1:0] == rd_ptr[AP-1:0]);
    assign nivel = wr_ptr - rd_ptr;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign rd_do = rd_en && !empty;
    assign wr_do = wr_en && (!full || rd_do);

    assign rd_dato = empty ? 8'h00 : mem[rd_ptr[AP-1:0]];

    always_ff @(posedge clk_i) begin
        if (wr_do) begin
            mem[wr_ptr[AP-1:0]] <= wr_dato;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_do) wr_ptr <= wr_ptr + 1'b1;
            if (rd_do) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/verif_trama.sv
// Frame checker and receive buffer behind the UART bit-capture stage.
// Optional error/overrun counters are built when VERIF_TRAMA_CONT_EN is defined.
module verif_trama
    import uart_pkg::*;
#(
    parameter  int PROF = 4,
    localparam int AP   = $clog2(PROF)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ANCHO_TRAMA-1:0] trama_i,
    input  logic                   dato_compl_i,
    output logic [7:0]             dato_o,
    output logic                   dato_valid_o,
    input  logic                   dato_listo_i,
    output logic [AP:0]            nivel_o,
    output logic                   err_trama_o,
    output logic                   overrun_o,
    output logic [7:0]             cont_err_o,
    output logic [7:0]             cont_ovr_o,
    output estado_t                estado_o
);

    estado_t                estado;
    estado_t                estado_sig;
    logic                   compl_q;
    logic                   subida;
    logic [ANCHO_TRAMA-1:0] trama_r;
    logic                   wr_en;
    logic                   err_nxt;
    logic                   ovr_nxt;
    logic                   pop;
    logic                   full;
    logic                   empty;

    // Handshake: a byte is consumed at the edge where dato_valid_o && dato_listo_i.
    assign pop          = dato_valid_o && dato_listo_i;
    assign dato_valid_o = !empty;
    assign estado_o     = estado;

    // compl_q resets high so a level already asserted at reset release is ignored.
    assign subida = dato_compl_i && !compl_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            estado      <= ESPERA;
            compl_q     <= 1'b1;
            trama_r     <= '0;
            err_trama_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            estado      <= estado_sig;
            compl_q     <= dato_compl_i;
            err_trama_o <= err_nxt;
            overrun_o   <= ovr_nxt;
            if (estado == ESPERA && subida) begin
                trama_r <= trama_i;
            end
        end
    end

    always_comb begin
        estado_sig = estado;
        wr_en      = 1'b0;
        err_nxt    = 1'b0;
        ovr_nxt    = 1'b0;
        case (estado)
            ESPERA: begin
                if (subida) estado_sig = VERIFICA;
            end
            VERIFICA: begin
                estado_sig = ESPERA;
                if (!trama_ok(trama_r)) begin
                    err_nxt = 1'b1;
                end else if (!full || pop) begin
                    wr_en = 1'b1;
                end else begin
                    ovr_nxt = 1'b1;
                end
            end
            default: estado_sig = ESPERA;
        endcase
    end

    fifo_rx #(.PROF(PROF)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (wr_en),
        .wr_dato (trama_r[MSB_DATO:LSB_DATO]),
        .rd_en   (pop),
        .rd_dato (dato_o),
        .full    (full),
        .empty   (empty),
        .nivel   (nivel_o)
    );

`ifdef VERIF_TRAMA_CONT_EN
    logic [7:0] cont_err_q;
    logic [7:0] cont_ovr_q;

    // Counters step on the same edge the corresponding pulse is raised.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cont_err_q <= '0;
            cont_ovr_q <= '0;
        end else begin
            if (err_nxt && cont_err_q != CONT_MAX) cont_err_q <= cont_err_q + 8'd1;
            if (ovr_nxt && cont_ovr_q != CONT_MAX) cont_ovr_q <= cont_ovr_q + 8'd1;
        end
    end

    assign cont_err_o = cont_err_q;
    assign cont_ovr_o = cont_ovr_q;
`else
    assign cont_err_o = 8'h00;
    assign cont_ovr_o = 8'h00;
`endif

endmodule
